// File: rtl/linebuf_reader.sv
// rtl/linebuf_reader.sv - line buffer configure/kick/poll/drain sequencer on a simple command bus
// Optional macro LBRD_TIMEOUT_EN adds a KICK/POLL timeout that sets a sticky err.
module linebuf_reader #(
    parameter int POLL_GAP       = 16,
    parameter int TIMEOUT_CYCLES = 4194304
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [8:0]  cfg_line_addr,
    input  logic [4:0]  cfg_line_size,
    input  logic [15:0] cfg_byte_count,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [2:0]  lb_MCmd,
    output logic [7:0]  lb_MAddr,
    output logic [7:0]  lb_MData,
    input  logic        lb_SCmdAccept,
    input  logic [7:0]  lb_SData,
    input  logic [1:0]  lb_SResp,
    output logic        out_valid,
    output logic [7:0]  out_data,
    input  logic        out_ready
);

    localparam logic [2:0] CMD_IDLE = 3'b000;
    localparam logic [2:0] CMD_WR   = 3'b001;
    localparam logic [2:0] CMD_RD   = 3'b010;
    localparam logic [1:0] RESP_DVA = 2'b01;

    typedef enum logic [2:0] {S_IDLE, S_CFG, S_KICK, S_POLL, S_DRAIN, S_FINISH} state_t;

    state_t      state;
    logic [8:0]  addr_q;
    logic [4:0]  size_q;
    logic [15:0] count_q;
    logic [15:0] remaining;
    logic [1:0]  cfg_idx;
    logic [7:0]  gap_cnt;
    logic        rd_pend;
    logic [7:0]  cfg_wr_addr;
    logic [7:0]  cfg_wr_data;

    logic accepted, resp_ok, bus_free, out_free;
    assign accepted = (lb_MCmd != CMD_IDLE) && lb_SCmdAccept;
    assign resp_ok  = rd_pend && (lb_SResp == RESP_DVA);
    assign bus_free = (lb_MCmd == CMD_IDLE) && !rd_pend;
    assign out_free = !out_valid || out_ready;

    always_comb begin
        cfg_wr_addr = 8'h10;
        cfg_wr_data = 8'h01;
        case (cfg_idx)
            2'd0: begin cfg_wr_addr = 8'h20; cfg_wr_data = addr_q[7:0]; end
            2'd1: begin cfg_wr_addr = 8'h21; cfg_wr_data = {7'b0, addr_q[8]}; end
            2'd2: begin cfg_wr_addr = 8'h30; cfg_wr_data = {3'b0, size_q}; end
            default: ;
        endcase
    end

`ifdef LBRD_TIMEOUT_EN
    logic [31:0] to_cnt;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            addr_q    <= '0;
            size_q    <= '0;
            count_q   <= '0;
            remaining <= '0;
            cfg_idx   <= '0;
            gap_cnt   <= '0;
            rd_pend   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            lb_MCmd   <= CMD_IDLE;
            lb_MAddr  <= '0;
            lb_MData  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
`ifdef LBRD_TIMEOUT_EN
            err       <= 1'b0;
            to_cnt    <= '0;
`endif
        end else begin
            done <= 1'b0;
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            // A command leaves the bus the edge it is accepted, guaranteeing an idle gap.
            if (accepted) begin
                lb_MCmd <= CMD_IDLE;
                if (lb_MCmd == CMD_RD)
                    rd_pend <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        addr_q  <= cfg_line_addr;
                        size_q  <= cfg_line_size;
                        count_q <= cfg_byte_count;
                        cfg_idx <= '0;
                        busy    <= 1'b1;
                        state   <= S_CFG;
`ifdef LBRD_TIMEOUT_EN
                        err     <= 1'b0;
`endif
                    end
                end
                S_CFG: begin
                    if (accepted) begin
                        if (cfg_idx == 2'd3) begin
                            state   <= S_KICK;
                            gap_cnt <= '0;
                        end else begin
                            cfg_idx <= cfg_idx + 2'd1;
                        end
                    end else if (bus_free) begin
                        lb_MCmd  <= CMD_WR;
                        lb_MAddr <= cfg_wr_addr;
                        lb_MData <= cfg_wr_data;
                    end
                end
                S_KICK, S_POLL: begin
                    // KICK must see the start bit consumed before trusting the capture-end flag.
                    if (resp_ok) begin
                        rd_pend <= 1'b0;
                        gap_cnt <= 8'(POLL_GAP);
                        if (state == S_KICK) begin
                            if (!lb_SData[0])
                                state <= S_POLL;
                        end else if (lb_SData[0]) begin
                            remaining <= count_q;
                            state     <= (count_q == 16'd0) ? S_FINISH : S_DRAIN;
                        end
                    end else if (bus_free) begin
                        if (gap_cnt != 8'd0) begin
                            gap_cnt <= gap_cnt - 8'd1;
                        end else begin
                            lb_MCmd  <= CMD_RD;
                            lb_MAddr <= (state == S_KICK) ? 8'h10 : 8'h14;
                            lb_MData <= '0;
                        end
                    end
                end
                S_DRAIN: begin
                    if (resp_ok) begin
                        rd_pend   <= 1'b0;
                        out_data  <= lb_SData;
                        out_valid <= 1'b1;
                    end else if (bus_free && out_free) begin
                        if (remaining != 16'd0) begin
                            lb_MCmd   <= CMD_RD;
                            lb_MAddr  <= 8'h00;
                            lb_MData  <= '0;
                            remaining <= remaining - 16'd1;
                        end else begin
                            state <= S_FINISH;
                        end
                    end
                end
                S_FINISH: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
`ifdef LBRD_TIMEOUT_EN
            if (state == S_KICK || state == S_POLL) begin
                if (to_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
                    state   <= S_IDLE;
                    err     <= 1'b1;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    lb_MCmd <= CMD_IDLE;
                    rd_pend <= 1'b0;
                    to_cnt  <= '0;
                end else begin
                    to_cnt <= to_cnt + 32'd1;
                end
            end else begin
                to_cnt <= '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_linebuf_reader.sv
// tb/tb_linebuf_reader.sv - directed self-checking bench for linebuf_reader with a line buffer slave model
module tb_linebuf_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [8:0]  cfg_line_addr = '0;
    logic [4:0]  cfg_line_size = '0;
    logic [15:0] cfg_byte_count = '0;
    logic        busy, done, err;
    logic [2:0]  lb_MCmd;
    logic [7:0]  lb_MAddr, lb_MData;
    logic        lb_SCmdAccept;
    logic [7:0]  lb_SData = 8'hEE;
    logic [1:0]  lb_SResp = 2'b00;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready = 1'b1;

    always #5 clk = ~clk;

    linebuf_reader #(.POLL_GAP(4), .TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_line_addr(cfg_line_addr), .cfg_line_size(cfg_line_size), .cfg_byte_count(cfg_byte_count),
        .busy(busy), .done(done), .err(err),
        .lb_MCmd(lb_MCmd), .lb_MAddr(lb_MAddr), .lb_MData(lb_MData),
        .lb_SCmdAccept(lb_SCmdAccept), .lb_SData(lb_SData), .lb_SResp(lb_SResp),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic       accept_en = 1'b1;
    assign lb_SCmdAccept = accept_en;

    int         kick_busy = 0;
    logic [7:0] reg14 = 8'h00;
    logic       kick_clear = 1'b0;
    int         rd10 = 0, rd14 = 0, rd00 = 0, bad_order = 0, done_cnt = 0;
    logic [7:0] fifo[$];
    logic [7:0] rx[$];
    logic [7:0] wr_a[$];
    logic [7:0] wr_d[$];
    logic       resp_pend = 1'b0;
    logic [7:0] resp_dat = 8'h00;

    // Slave: a command seen with accept high at this negedge is taken at the next posedge,
    // and its response is presented for the whole following cycle.
    always @(negedge clk) begin
        if (resp_pend) begin
            lb_SResp  = 2'b01;
            lb_SData  = resp_dat;
            resp_pend = 1'b0;
        end else begin
            lb_SResp = 2'b00;
            lb_SData = 8'hEE;
        end
        if (!rst && lb_MCmd != 3'b000 && accept_en) begin
            if (lb_MCmd == 3'b001) begin
                wr_a.push_back(lb_MAddr);
                wr_d.push_back(lb_MData);
            end else begin
                resp_pend = 1'b1;
                case (lb_MAddr)
                    8'h10: begin
                        rd10++;
                        if (kick_busy > 0) begin kick_busy--; resp_dat = 8'h01; end
                        else begin kick_clear = 1'b1; resp_dat = 8'h00; end
                    end
                    8'h14: begin
                        rd14++;
                        if (!kick_clear) bad_order++;
                        resp_dat = reg14;
                    end
                    8'h00: begin
                        rd00++;
                        resp_dat = (fifo.size() > 0) ? fifo.pop_front() : 8'hFF;
                    end
                    default: resp_dat = 8'h00;
                endcase
            end
        end
        if (done) done_cnt++;
        if (out_valid && out_ready) rx.push_back(out_data);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic setup(input int kb, input logic [7:0] r14);
        kick_busy = kb; reg14 = r14; kick_clear = 1'b0;
        rd10 = 0; rd14 = 0; rd00 = 0; bad_order = 0; done_cnt = 0;
        fifo.delete(); rx.delete(); wr_a.delete(); wr_d.delete();
    endtask

    task automatic kick_off(input logic [8:0] a, input logic [4:0] s, input logic [15:0] c);
        tick;
        cfg_line_addr = a; cfg_line_size = s; cfg_byte_count = c;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    task automatic wait_done(input int target, input string tag);
        int n = 0;
        while (done_cnt < target && n < 3000) begin
            tick;
            n++;
        end
        check(tag, done_cnt, target);
    endtask

    initial begin
        logic [7:0] ea[4];
        logic [7:0] ed[4];
        logic [7:0] eb[4];
        logic [7:0] d0;
        int unstable, n;

        tick; tick;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_mcmd", lb_MCmd, 0);
        check("rst_maddr", lb_MAddr, 0);
        check("rst_outv", out_valid, 0);
        check("rst_outd", out_data, 0);
        rst = 1'b0;

        // Full flow with a stale capture-end flag and a slow-clearing start bit.
        setup(3, 8'h01);
        fifo.push_back(8'hA1); fifo.push_back(8'hB2); fifo.push_back(8'hC3); fifo.push_back(8'hD4);
        kick_off(9'h105, 5'd20, 16'd4);
        check("busy_after_start", busy, 1);
        wait_done(1, "a_done");
        ea = '{8'h20, 8'h21, 8'h30, 8'h10};
        ed = '{8'h05, 8'h01, 8'h14, 8'h01};
        eb = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        check("a_nwr", wr_a.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("a_wr_addr%0d", i), wr_a[i], ea[i]);
            check($sformatf("a_wr_data%0d", i), wr_d[i], ed[i]);
        end
        check("a_rd10", rd10, 4);
        check("a_stale_order", bad_order, 0);
        check("a_rd00", rd00, 4);
        check("a_nrx", rx.size(), 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("a_byte%0d", i), rx[i], eb[i]);
        tick; tick;
        check("a_busy_end", busy, 0);
        check("a_single_done", done_cnt, 1);

        // Write held while the slave refuses it.
        setup(0, 8'h01);
        fifo.push_back(8'h11); fifo.push_back(8'h22);
        accept_en = 1'b0;
        kick_off(9'h0AA, 5'd3, 16'd2);
        n = 0;
        while (lb_MCmd == 3'b000 && n < 20) begin tick; n++; end
        check("b_mcmd", lb_MCmd, 3'b001);
        check("b_maddr", lb_MAddr, 8'h20);
        check("b_mdata", lb_MData, 8'hAA);
        unstable = 0;
        repeat (5) begin
            tick;
            if (lb_MCmd !== 3'b001 || lb_MAddr !== 8'h20 || lb_MData !== 8'hAA) unstable++;
        end
        check("b_hold", unstable, 0);
        accept_en = 1'b1;
        wait_done(1, "b_done");
        check("b_nwr", wr_a.size(), 4);
        check("b_wr0", wr_a[0], 8'h20);
        check("b_wr1_data", wr_d[1], 8'h00);
        check("b_wr2_data", wr_d[2], 8'h03);
        check("b_byte0", rx[0], 8'h11);
        check("b_byte1", rx[1], 8'h22);

        // Backpressure stall plus a start pulse while busy.
        setup(1, 8'h01);
        fifo.push_back(8'h5A); fifo.push_back(8'h6B); fifo.push_back(8'h7C);
        out_ready = 1'b0;
        kick_off(9'h033, 5'd7, 16'd3);
        tick; tick;
        cfg_line_addr = 9'h1FF; start = 1'b1;
        tick;
        start = 1'b0;
        n = 0;
        while (!out_valid && n < 500) begin tick; n++; end
        check("c_first_valid", out_valid, 1);
        d0 = out_data;
        check("c_first_byte", d0, 8'h5A);
        unstable = 0;
        repeat (50) begin
            tick;
            if (out_valid !== 1'b1 || out_data !== d0) unstable++;
        end
        check("c_stall_stable", unstable, 0);
        check("c_stall_reads", rd00, 1);
        out_ready = 1'b1;
        wait_done(1, "c_done");
        check("c_nwr", wr_a.size(), 4);
        check("c_wr0_data", wr_d[0], 8'h33);
        check("c_rd00", rd00, 3);
        check("c_byte2", rx[2], 8'h7C);

        // Asynchronous reset in the middle of a drain.
        setup(0, 8'h01);
        fifo.push_back(8'h99); fifo.push_back(8'h98);
        out_ready = 1'b0;
        kick_off(9'h010, 5'd1, 16'd2);
        n = 0;
        while (!out_valid && n < 500) begin tick; n++; end
        check("e_valid_before_rst", out_valid, 1);
        #2 rst = 1'b1;
        #1;
        check("e_rst_outv", out_valid, 0);
        check("e_rst_outd", out_data, 0);
        check("e_rst_busy", busy, 0);
        check("e_rst_mcmd", lb_MCmd, 0);
        check("e_rst_mdata", lb_MData, 0);
        tick;
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (5) tick;
        check("e_idle_after", busy, 0);
        check("e_no_done", done_cnt, 0);

        // Zero byte count skips the drain.
        setup(0, 8'h01);
        kick_off(9'h000, 5'd0, 16'd0);
        wait_done(1, "d_done");
        check("d_rd00", rd00, 0);
        check("d_rd14", rd14, 1);
        check("d_nrx", rx.size(), 0);
        tick;
        check("d_busy", busy, 0);

`ifdef LBRD_TIMEOUT_EN
        setup(0, 8'h00);
        kick_off(9'h000, 5'd0, 16'd2);
        wait_done(1, "t_done");
        tick;
        check("t_err", err, 1);
        check("t_busy", busy, 0);
        setup(0, 8'h01);
        kick_off(9'h000, 5'd0, 16'd0);
        check("t_err_cleared", err, 0);
        wait_done(1, "t_recover_done");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/linebuf_reader.md
LINEBUF_READER -- requirements
Module: linebuf_reader

Interface
REQ-001 Parameter POLL_GAP, default 16: idle cycles between consecutive status polls (1..255).
REQ-002 Parameter TIMEOUT_CYCLES, default 4194304: poll-phase timeout limit (used only with LBRD_TIMEOUT_EN).
REQ-003 Port clk input 1: single clock, same domain as the line buffer bus side.
REQ-004 Port rst input 1: reset, asynchronous, active-high.
REQ-005 Ports: start input 1 (one-cycle request); cfg_line_addr input 9 (first line); cfg_line_size input 5 (line count); cfg_byte_count input 16 (bytes to drain, 0 = none).
REQ-006 Ports: busy output 1; done output 1 (one-cycle pulse); err output 1 (sticky timeout flag).
REQ-007 Ports: lb_MCmd output 3; lb_MAddr output 8; lb_MData output 8; lb_SCmdAccept input 1; lb_SData input 8; lb_SResp input 2.
REQ-008 Ports: out_valid output 1; out_data output 8; out_ready input 1.

Function
REQ-009 Bus commands SHALL be IDLE=000, WR=001, RD=010; each command and its MAddr/MData SHALL be held until sampled with lb_SCmdAccept=1, then MCmd SHALL return to IDLE for at least one cycle.
REQ-010 A read SHALL complete on the first cycle after acceptance with lb_SResp=01; lb_SData SHALL be captured that cycle; responses in any other state SHALL be ignored.
REQ-011 In IDLE, start=1 SHALL latch all cfg_* inputs, assert busy, and enter CFG; start while busy SHALL be ignored.
REQ-012 CFG SHALL issue four writes in order: 0x20<-addr[7:0], 0x21<-{7'b0,addr[8]}, 0x30<-{3'b0,size}, 0x10<-0x01.
REQ-013 KICK state SHALL read 0x10 every POLL_GAP idle cycles until SData[0]=0, confirming the capture start was consumed, so that a stale capture-end flag from a prior frame is never trusted.
REQ-014 POLL state SHALL read 0x14 every POLL_GAP idle cycles until SData[0]=1, then enter DRAIN.
REQ-015 DRAIN SHALL read 0x00 once per byte; it SHALL issue a read only when the output register is empty or is being emptied that cycle (out_valid & out_ready).
REQ-016 The returned byte SHALL load out_data and set out_valid the cycle after the response; out_valid/out_data SHALL hold until out_ready=1.
REQ-017 A 16-bit remaining counter SHALL decrement on each issued read; at zero, no further reads SHALL be issued. After the final byte is handed off, done SHALL pulse for one cycle, busy SHALL drop, and the state SHALL return to IDLE.
REQ-018 cfg_byte_count=0 SHALL skip DRAIN: done SHALL pulse the cycle after POLL completes.
REQ-019 Backpressure: out_ready held 0 SHALL stall the block indefinitely with no extra bus reads and no data loss.
REQ-020 States: IDLE, CFG, KICK, POLL, DRAIN, FINISH; no other reachable states.

Reset
REQ-021 rst=1 SHALL immediately force IDLE, lb_MCmd=000, lb_MAddr=0x00, lb_MData=0x00, busy=0, done=0, err=0, out_valid=0, out_data=0x00, with all counters cleared.
REQ-022 Reset mid-operation SHALL abandon the transfer silently; any in-flight response after reset SHALL be ignored.

Configuration
REQ-023 Macro LBRD_TIMEOUT_EN defined: a counter SHALL run during KICK and POLL; on reaching TIMEOUT_CYCLES it SHALL set err=1, pulse done, and return to IDLE. err SHALL clear on the next accepted start.
REQ-024 LBRD_TIMEOUT_EN undefined: no timeout counter; KICK/POLL wait forever; err SHALL be tied to 0.

Verification
REQ-025 start with addr=0x105, size=20, count=4, SCmdAccept=1 -> writes (0x20,0x05), (0x21,0x01), (0x30,0x14), (0x10,0x01) in order.
REQ-026 Model holds 0x14 bit0=1 (stale) but 0x10 bit0=1 for 3 polls -> no 0x14 read occurs until 0x10 reads 0.
REQ-027 FIFO bytes A1,B2,C3,D4, out_ready=1 -> out_data A1,B2,C3,D4 in order, exactly 4 reads of 0x00, one done pulse.
REQ-028 out_ready=0 for 50 cycles mid-drain -> out_valid=1 with stable data, no reads of 0x00 issued.
REQ-029 SCmdAccept=0 for 5 cycles on the first write -> MCmd/MAddr/MData held constant, no duplicate write.
REQ-030 With LBRD_TIMEOUT_EN and TIMEOUT_CYCLES=100, capture end never set -> err=1, done pulse, busy=0; rst asserted mid-drain -> all outputs at reset values immediately.
